// File: rtl/dmi_access_fsm.sv
// DMI access sequencer: turns transport-side DMI commands into valid/ready
// requests toward the debug module and tracks the sticky dmistat error.
package dm;
    localparam int unsigned DmiAddrW = 7;
    localparam int unsigned DmiDataW = 32;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [DmiAddrW-1:0] addr;
        dtm_op_e             op;
        logic [DmiDataW-1:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [DmiDataW-1:0] data;
        logic [1:0]          resp;
    } dmi_resp_t;
endpackage

module dmi_access_fsm #(
    parameter int unsigned AddrWidth = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [1:0]           cmd_op_i,
    input  logic [31:0]          cmd_data_i,
    input  logic                 capture_i,
    input  logic                 dmireset_i,
    input  logic                 dmihardreset_i,
    output logic [1:0]           status_o,
    output logic [31:0]          rdata_o,
    output logic                 busy_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output dm::dmi_req_t         dmi_req_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  dm::dmi_resp_t        dmi_resp_i
);

    localparam int unsigned ReqAddrW = dm::DmiAddrW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_READ,
        S_WRITE,
        S_WAIT_WRITE
    } state_e;

    state_e       r_state;
    logic         r_req_valid;
    dm::dmi_req_t r_req;
    logic [1:0]   r_status;
    logic [31:0]  r_rdata;

    logic w_idle;
    logic w_waiting;
    logic w_busy_err;
    logic w_resp_err;
    logic w_cmd_accept;

    assign w_idle       = (r_state == S_IDLE);
    assign w_waiting    = (r_state == S_WAIT_READ) || (r_state == S_WAIT_WRITE);
    assign w_busy_err   = !w_idle && (cmd_valid_i || capture_i);
    // Stray responses seen in Idle never count as errors.
    assign w_resp_err   = w_waiting && dmi_resp_valid_i && (dmi_resp_i.resp != 2'd0);
    assign w_cmd_accept = w_idle && cmd_valid_i && (r_status == 2'd0) && !dmihardreset_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_req_valid <= 1'b0;
            r_req       <= '0;
            r_status    <= 2'd0;
            r_rdata     <= 32'd0;
        end else begin
            // Sticky error: first one wins, clears take priority.
            if (dmireset_i || dmihardreset_i) begin
                r_status <= 2'd0;
            end else if (r_status == 2'd0) begin
                if (w_resp_err) begin
                    r_status <= dmi_resp_i.resp;
                end else if (w_busy_err) begin
                    r_status <= 2'd3;
                end
            end

            if (dmihardreset_i) begin
                r_state     <= S_IDLE;
                r_req_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cmd_accept) begin
                            r_req.addr <= ReqAddrW'(cmd_addr_i);
                            r_req.data <= cmd_data_i;
                            if (cmd_op_i == 2'd1) begin
                                r_req.op    <= dm::DTM_READ;
                                r_req_valid <= 1'b1;
                                r_state     <= S_READ;
                            end else if (cmd_op_i == 2'd2) begin
                                r_req.op    <= dm::DTM_WRITE;
                                r_req_valid <= 1'b1;
                                r_state     <= S_WRITE;
                            end
                        end
                    end
                    S_READ: begin
                        if (dmi_req_ready_i) begin
                            r_req_valid <= 1'b0;
                            r_state     <= S_WAIT_READ;
                        end
                    end
                    S_WRITE: begin
                        if (dmi_req_ready_i) begin
                            r_req_valid <= 1'b0;
                            r_state     <= S_WAIT_WRITE;
                        end
                    end
                    S_WAIT_READ: begin
                        if (dmi_resp_valid_i) begin
                            if (dmi_resp_i.resp == 2'd0) begin
                                r_rdata <= dmi_resp_i.data;
                            end
                            r_state <= S_IDLE;
                        end
                    end
                    S_WAIT_WRITE: begin
                        if (dmi_resp_valid_i) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_req_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign status_o         = r_status;
    assign rdata_o          = r_rdata;
    assign dmi_req_valid_o  = r_req_valid;
    assign dmi_req_o        = r_req;
    assign busy_o           = !w_idle;
    assign dmi_resp_ready_o = w_idle || w_waiting;

endmodule
